// File: rtl/alu_pkg.sv
// Shared types for the sequential add/sub/and/xor ALU: opcodes, FSM states, flags.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
    logic cf;
  } alu_flags_t;

  function automatic logic op_is_arith(alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_chunk.sv
// One CHUNK-wide slice of the ALU, purely combinational; sub is formed as a + ~b + carry_in.
module alu_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  alu_op_t          op,
  input  logic             carry_in,
  output logic [CHUNK-1:0] r,
  output logic             carry_out,
  output logic             msb_carry_in
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  always_comb begin
    b_eff     = (op == ALU_SUB) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_in};
    carry_out = sum[CHUNK];
    // Carry into the top bit, recovered from the top bit's sum equation.
    msb_carry_in = a[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum[CHUNK-1];
    unique case (op)
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
      default: r = sum[CHUNK-1:0];
    endcase
  end

endmodule

// File: rtl/seq_alu_addsub.sv
// Multi-cycle ALU (add/sub/and/xor + ZF/SF/OF/CF), CHUNK bits per cycle; SEQ_ALU_CC_REG_EN adds a CC register.
// Result valid NCHUNK cycles after accept; out_ready low holds DONE, in_valid ignored outside IDLE.
module seq_alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
`ifdef SEQ_ALU_CC_REG_EN
  input  logic             set_cc,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_cf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_alu_addsub: WIDTH must be >= 2");
  end
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("seq_alu_addsub: WIDTH must be a multiple of CHUNK");
  end

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_t          op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  alu_flags_t       flags_q, flags_d;

  logic [IW-1:0]    base;
  logic [CHUNK-1:0] chunk_r;
  logic             chunk_co;
  logic             chunk_msb_ci;

  assign base = IW'(cnt_q) * IW'(CHUNK);

  // Single slice reused every BUSY cycle; the counter steers which bits it sees.
  alu_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a           (a_q[base +: CHUNK]),
    .b           (b_q[base +: CHUNK]),
    .op          (op_q),
    .carry_in    (carry_q),
    .r           (chunk_r),
    .carry_out   (chunk_co),
    .msb_carry_in(chunk_msb_ci)
  );

`ifdef SEQ_ALU_CC_REG_EN
  logic set_cc_q, set_cc_d;
  logic cc_zf_q, cc_zf_d;
  logic cc_sf_q, cc_sf_d;
  logic cc_of_q, cc_of_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    flags_d = flags_q;
`ifdef SEQ_ALU_CC_REG_EN
    set_cc_d = set_cc_q;
    cc_zf_d  = cc_zf_q;
    cc_sf_d  = cc_sf_q;
    cc_of_d  = cc_of_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = alu_op_t'(in_op);
          carry_d = (alu_op_t'(in_op) == ALU_SUB);
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef SEQ_ALU_CC_REG_EN
          set_cc_d = set_cc;
`endif
        end
      end
      ST_BUSY: begin
        res_d[base +: CHUNK] = chunk_r;
        carry_d              = chunk_co;
        if (cnt_q == LAST) begin
          // Last slice holds the MSB, so its carries give the word-level CF/OF.
          flags_d.zf = (res_d == '0);
          flags_d.sf = res_d[WIDTH-1];
          flags_d.of = op_is_arith(op_q) && (chunk_msb_ci ^ chunk_co);
          flags_d.cf = (op_q == ALU_ADD) ? chunk_co :
                       (op_q == ALU_SUB) ? ~chunk_co : 1'b0;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
`ifdef SEQ_ALU_CC_REG_EN
          if (set_cc_q) begin
            cc_zf_d = flags_q.zf;
            cc_sf_d = flags_q.sf;
            cc_of_d = flags_q.of;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

`ifdef SEQ_ALU_CC_REG_EN
  // Architectural CC resets to "zero result" as Y86 expects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_cc_q <= 1'b0;
      cc_zf_q  <= 1'b1;
      cc_sf_q  <= 1'b0;
      cc_of_q  <= 1'b0;
    end else begin
      set_cc_q <= set_cc_d;
      cc_zf_q  <= cc_zf_d;
      cc_sf_q  <= cc_sf_d;
      cc_of_q  <= cc_of_d;
    end
  end

  assign cc_zf = cc_zf_q;
  assign cc_sf = cc_sf_q;
  assign cc_of = cc_of_q;
`endif

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = res_q;
  assign out_zf     = flags_q.zf;
  assign out_sf     = flags_q.sf;
  assign out_of     = flags_q.of;
  assign out_cf     = flags_q.cf;

endmodule

// File: tb/tb_seq_alu_addsub.sv
// Randomised and directed check of seq_alu_addsub against an arithmetic reference model.
module tb_seq_alu_addsub;
  import alu_pkg::*;

  localparam int W = 64;
  localparam int C = 16;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_op = 2'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zf, out_sf, out_of, out_cf;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [7:0] s_a = '0;
  logic [7:0] s_b = '0;
  logic [1:0] s_op = 2'd0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  logic [7:0] s_res;
  logic       s_zf, s_sf, s_of, s_cf;

`ifdef SEQ_ALU_CC_REG_EN
  logic set_cc = 1'b0;
  logic cc_zf, cc_sf, cc_of;
  logic s_set_cc = 1'b0;
  logic s_cc_zf, s_cc_sf, s_cc_of;
`endif

  seq_alu_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
`ifdef SEQ_ALU_CC_REG_EN
    .set_cc(set_cc), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result),
    .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of), .out_cf(out_cf)
  );

  seq_alu_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_a), .in_b(s_b), .in_op(s_op),
`ifdef SEQ_ALU_CC_REG_EN
    .set_cc(s_set_cc), .cc_zf(s_cc_zf), .cc_sf(s_cc_sf), .cc_of(s_cc_of),
`endif
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_result(s_res),
    .out_zf(s_zf), .out_sf(s_sf), .out_of(s_of), .out_cf(s_cf)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] r;
    logic zf, sf, of, cf;
  } exp_t;

  // Reference: unsigned wide sums for CF, signed wide sums for OF.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] wide;
    logic signed [W+1:0] sa, sb, ss, rs;
    sa = $signed(a);
    sb = $signed(b);
    e.of = 1'b0;
    e.cf = 1'b0;
    case (op)
      2'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        e.r  = wide[W-1:0];
        e.cf = wide[W];
        ss   = sa + sb;
        rs   = $signed(e.r);
        e.of = (ss != rs);
      end
      2'd1: begin
        e.r  = a - b;
        e.cf = (a < b);
        ss   = sa - sb;
        rs   = $signed(e.r);
        e.of = (ss != rs);
      end
      2'd2: e.r = a & b;
      default: e.r = a ^ b;
    endcase
    e.zf = (e.r == '0);
    e.sf = e.r[W-1];
    return e;
  endfunction

  exp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_valid_exclusive", {63'd0, in_ready & out_valid}, 64'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          check("result", out_result, exp_q[0].r);
          check("zf", {63'd0, out_zf}, {63'd0, exp_q[0].zf});
          check("sf", {63'd0, out_sf}, {63'd0, exp_q[0].sf});
          check("of", {63'd0, out_of}, {63'd0, exp_q[0].of});
          check("cf", {63'd0, out_cf}, {63'd0, exp_q[0].cf});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit pulse);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_req", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    @(posedge clk);
    exp_q.push_back(model(op, a, b));
    #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_op = 2'($urandom_range(0, 3));
    check("in_ready_busy", {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(N));
    for (int i = 0; i < hold; i++) begin
      if (pulse) in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check("in_ready_held", {63'd0, in_ready}, 64'd0);
      check("valid_held", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    if (pulse) in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("handoff_valid_low", {63'd0, out_valid}, 64'd0);
    check("handoff_ready_high", {63'd0, in_ready}, 64'd1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  logic [2:0] exp_cc = 3'b100;

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit sc,
                      input logic [7:0] er, input logic [3:0] eflags);
`ifdef SEQ_ALU_CC_REG_EN
    s_set_cc = sc;
`endif
    s_a = a; s_b = b; s_op = op; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("w8_busy_no_valid", {63'd0, s_out_valid}, 64'd0);
    @(posedge clk); #1;
    check("w8_valid_after_one", {63'd0, s_out_valid}, 64'd1);
    check("w8_result", {56'd0, s_res}, {56'd0, er});
    check("w8_flags", {60'd0, s_zf, s_sf, s_of, s_cf}, {60'd0, eflags});
`ifdef SEQ_ALU_CC_REG_EN
    check("w8_cc_before_handoff", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, {61'd0, exp_cc});
`endif
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    if (sc) exp_cc = eflags[3:1];
    check("w8_idle", {63'd0, s_in_ready}, 64'd1);
`ifdef SEQ_ALU_CC_REG_EN
    check("w8_cc_after_handoff", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, {61'd0, exp_cc});
`endif
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    exp_t e;
    #2;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", out_result, 64'd0);
    check("reset_flags", {60'd0, out_zf, out_sf, out_of, out_cf}, 64'd0);
`ifdef SEQ_ALU_CC_REG_EN
    check("reset_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pin the reference model to hand-computed values.
    e = model(2'd1, 64'h8000_0000_0000_0000, 64'd1);
    check("model_sub_min", e.r, 64'h7FFF_FFFF_FFFF_FFFF);
    check("model_sub_min_flags", {60'd0, e.zf, e.sf, e.of, e.cf}, 64'b0010);
    e = model(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("model_add_max", e.r, 64'h8000_0000_0000_0000);
    check("model_add_max_flags", {60'd0, e.zf, e.sf, e.of, e.cf}, 64'b0110);
    e = model(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("model_add_wrap_flags", {60'd0, e.zf, e.sf, e.of, e.cf}, 64'b1001);
    e = model(2'd1, 64'd3, 64'd5);
    check("model_sub_neg", e.r, 64'hFFFF_FFFF_FFFF_FFFE);
    check("model_sub_neg_flags", {60'd0, e.zf, e.sf, e.of, e.cf}, 64'b0101);
    e = model(2'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("model_xor", e.r, 64'h0F0F_0F0F_0F0F_0F0F);

    run_op(2'd1, 64'h8000_0000_0000_0000, 64'd1, 1, 1'b0);
    run_op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    run_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2, 1'b0);
    run_op(2'd1, 64'd5, 64'd5, 0, 1'b0);
    run_op(2'd1, 64'd3, 64'd5, 0, 1'b0);
    run_op(2'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    run_op(2'd2, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_FFFF_0000, 0, 1'b0);

    // Backpressure with in_valid pulsing, including during the handoff cycle.
    run_op(2'd0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 5, 1'b1);
    repeat (N + 2) @(posedge clk);
    #1;
    check("no_stray_accept", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset in the second BUSY cycle.
    in_valid = 1'b1; in_op = 2'd0;
    in_a = 64'h0123_4567_89AB_CDEF; in_b = 64'h1111_1111_1111_1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("midop_reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midop_reset_result", out_result, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (N + 2) @(posedge clk);
    #1;
    check("midop_no_result", {63'd0, out_valid}, 64'd0);
    run_op(2'd1, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_0000_0001, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), $urandom_range(0, 3), 1'b0);
    end

    // Single-chunk build.
    check("w8_reset_cc_model", {61'd0, exp_cc}, 64'd4);
    run8(2'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0010);
    run8(2'd0, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0110);
    run8(2'd3, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b1000);
    run8(2'd1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
